// File: rtl/dcache_mshr_file.sv
// Data-cache MSHR file: tracks outstanding line misses, merges secondary misses, issues line
// fetches and replays waiting requests after refill. Define DCACHE_MSHR_MERGE_EN to enable merging.
module dcache_mshr_file #(
  parameter int MSHR_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 38,
  parameter int LINE_WIDTH   = 128,
  parameter int REQ_ID_WIDTH = 4,
  parameter int TARGETS      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr_i,
  input  logic [REQ_ID_WIDTH-1:0]       alloc_req_id_i,
  output logic                          alloc_merged_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  output logic [$clog2(MSHR_DEPTH)-1:0] mem_req_id_o,
  input  logic                          refill_valid_i,
  input  logic [$clog2(MSHR_DEPTH)-1:0] refill_id_i,
  input  logic [LINE_WIDTH-1:0]         refill_data_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [REQ_ID_WIDTH-1:0]       resp_req_id_o,
  output logic [ADDR_WIDTH-1:0]         resp_addr_o,
  output logic [LINE_WIDTH-1:0]         resp_data_o,
  output logic [$clog2(MSHR_DEPTH):0]   occupancy_o,
  output logic                          refill_err_o
);
  localparam int OFF = $clog2(LINE_WIDTH/8);
  localparam int LAW = ADDR_WIDTH - OFF;
  localparam int IDW = $clog2(MSHR_DEPTH);
`ifdef DCACHE_MSHR_MERGE_EN
  localparam int TGT = TARGETS;
`else
  localparam int TGT = 1;
`endif
  localparam int TW = (TGT > 1) ? $clog2(TGT) : 1;
  localparam int TS = 1 << TW;
  localparam int CW = $clog2(TGT + 1);

  typedef enum logic [1:0] {FREE, PENDING, ISSUED, REPLAY} st_e;

  st_e                     st_q   [MSHR_DEPTH];
  logic [LAW-1:0]          line_q [MSHR_DEPTH];
  logic [CW-1:0]           cnt_q  [MSHR_DEPTH];
  logic [TW-1:0]           hd_q   [MSHR_DEPTH];
  logic [ADDR_WIDTH-1:0]   taddr_q[MSHR_DEPTH][TS];
  logic [REQ_ID_WIDTH-1:0] tid_q  [MSHR_DEPTH][TS];
  logic [LINE_WIDTH-1:0]   data_q [MSHR_DEPTH];
  logic                    iss_hold_q, rsp_hold_q, err_q;
  logic [IDW-1:0]          iss_idx_q, rsp_idx_q;
  logic [IDW:0]            occ_q;

  logic           hit, hit_rep, free_ok, pend_ok, rep_ok;
  logic [IDW-1:0] hit_idx, free_idx, pend_idx, rep_idx, midx, ridx, aidx;
  logic [TW-1:0]  aslot;
  logic [IDW:0]   occ_d;
  logic           acc, mem_hs, rsp_hs, refill_ok, rsp_last;

  // Descending scan so the lowest index wins every priority pick.
  always_comb begin
    hit = 1'b0; hit_rep = 1'b0; hit_idx = '0;
    free_ok = 1'b0; free_idx = '0;
    pend_ok = 1'b0; pend_idx = '0;
    rep_ok = 1'b0; rep_idx = '0;
    occ_d = '0;
    for (int i = MSHR_DEPTH-1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        free_ok = 1'b1; free_idx = IDW'(i);
      end else begin
        occ_d = occ_d + 1'b1;
        if (line_q[i] == alloc_addr_i[ADDR_WIDTH-1:OFF]) begin
          hit = 1'b1; hit_idx = IDW'(i); hit_rep = (st_q[i] == REPLAY);
        end
      end
      if (st_q[i] == PENDING) begin pend_ok = 1'b1; pend_idx = IDW'(i); end
      if (st_q[i] == REPLAY)  begin rep_ok  = 1'b1; rep_idx  = IDW'(i); end
    end
  end

  assign alloc_ready_o = !rst_i && (hit ? (!hit_rep && (cnt_q[hit_idx] < CW'(TGT))) : free_ok);
  assign acc   = alloc_valid_i && alloc_ready_o;
  assign aidx  = hit ? hit_idx : free_idx;
  assign aslot = hit ? TW'(cnt_q[hit_idx]) : '0;
`ifdef DCACHE_MSHR_MERGE_EN
  assign alloc_merged_o = acc && hit;
`else
  assign alloc_merged_o = 1'b0;
`endif

  // A stalled fetch or replay keeps its entry so a lower-index newcomer cannot disturb it.
  assign midx            = iss_hold_q ? iss_idx_q : pend_idx;
  assign mem_req_valid_o = iss_hold_q || pend_ok;
  assign mem_req_addr_o  = mem_req_valid_o ? {line_q[midx], {OFF{1'b0}}} : '0;
  assign mem_req_id_o    = mem_req_valid_o ? midx : '0;
  assign mem_hs          = mem_req_valid_o && mem_req_ready_i;

  assign ridx          = rsp_hold_q ? rsp_idx_q : rep_idx;
  assign resp_valid_o  = rsp_hold_q || rep_ok;
  assign resp_req_id_o = resp_valid_o ? tid_q[ridx][hd_q[ridx]] : '0;
  assign resp_addr_o   = resp_valid_o ? taddr_q[ridx][hd_q[ridx]] : '0;
  assign resp_data_o   = resp_valid_o ? data_q[ridx] : '0;
  assign rsp_hs        = resp_valid_o && resp_ready_i;
  assign rsp_last      = (CW'(hd_q[ridx]) + CW'(1)) == cnt_q[ridx];

  assign refill_ok    = refill_valid_i && (st_q[refill_id_i] == ISSUED);
  assign occupancy_o  = occ_q;
  assign refill_err_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        st_q[i] <= FREE; line_q[i] <= '0; cnt_q[i] <= '0; hd_q[i] <= '0;
      end
      iss_hold_q <= 1'b0; iss_idx_q <= '0;
      rsp_hold_q <= 1'b0; rsp_idx_q <= '0;
      occ_q      <= '0;   err_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      err_q      <= err_q || (refill_valid_i && !refill_ok);
      iss_hold_q <= mem_req_valid_o && !mem_req_ready_i;
      iss_idx_q  <= midx;
      rsp_hold_q <= resp_valid_o && !resp_ready_i;
      rsp_idx_q  <= ridx;
      if (mem_hs)    st_q[midx] <= ISSUED;
      if (refill_ok) st_q[refill_id_i] <= REPLAY;
      if (acc) begin
        if (hit) begin
          cnt_q[hit_idx] <= cnt_q[hit_idx] + 1'b1;
        end else begin
          st_q[free_idx]   <= PENDING;
          line_q[free_idx] <= alloc_addr_i[ADDR_WIDTH-1:OFF];
          cnt_q[free_idx]  <= CW'(1);
          hd_q[free_idx]   <= '0;
        end
      end
      if (rsp_hs) begin
        if (rsp_last) st_q[ridx] <= FREE;
        else          hd_q[ridx] <= hd_q[ridx] + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: every read is gated by a valid state.
  always_ff @(posedge clk_i) begin
    if (refill_ok) data_q[refill_id_i] <= refill_data_i;
    if (acc) begin
      taddr_q[aidx][aslot] <= alloc_addr_i;
      tid_q[aidx][aslot]   <= alloc_req_id_i;
    end
  end
endmodule

// File: tb/tb_dcache_mshr_file.sv
// Self-checking bench for dcache_mshr_file: directed scenarios plus random traffic against an
// entry/target-queue reference model. Honours DCACHE_MSHR_MERGE_EN like the design.
module tb_dcache_mshr_file;
  localparam int NE = 16, AW = 38, LW = 128, IW = 4;
`ifdef DCACHE_MSHR_MERGE_EN
  localparam int TGT = 4;
`else
  localparam int TGT = 1;
`endif

  logic clk = 1'b0, rst;
  logic alloc_valid, alloc_ready_o, alloc_merged_o;
  logic [AW-1:0] alloc_addr;
  logic [IW-1:0] alloc_id;
  logic mem_req_valid_o, mem_ready;
  logic [AW-1:0] mem_req_addr_o;
  logic [3:0] mem_req_id_o;
  logic refill_valid;
  logic [3:0] refill_id;
  logic [LW-1:0] refill_data;
  logic resp_valid_o, resp_ready;
  logic [IW-1:0] resp_req_id_o;
  logic [AW-1:0] resp_addr_o;
  logic [LW-1:0] resp_data_o;
  logic [4:0] occupancy_o;
  logic refill_err_o;

  dcache_mshr_file #(.MSHR_DEPTH(NE), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .REQ_ID_WIDTH(IW), .TARGETS(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready_o), .alloc_addr_i(alloc_addr),
    .alloc_req_id_i(alloc_id), .alloc_merged_o(alloc_merged_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_ready),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .refill_valid_i(refill_valid), .refill_id_i(refill_id), .refill_data_i(refill_data),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_req_id_o(resp_req_id_o),
    .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o),
    .occupancy_o(occupancy_o), .refill_err_o(refill_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: entry states (0 free,1 pending,2 issued,3 replay) and one global queue of
  // waiting requests tagged with their entry; per-entry insertion order is queue order.
  typedef struct { int ent; logic [IW-1:0] id; logic [AW-1:0] addr; } tgt_t;
  tgt_t tq[$];
  int st[NE];
  logic [AW-1:0] mline[NE];
  logic [LW-1:0] mdat[NE];
  bit ihold, rhold, merr, auto_refill;
  int iidx, ridx, mocc;
  int total, bad;

  bit e_ready, e_merged, e_mv, e_rv;
  int e_hit, e_free, e_midx, e_ridx;
  logic [AW-1:0] e_maddr, e_raddr;
  logic [3:0] e_mid;
  logic [IW-1:0] e_rid;
  logic [LW-1:0] e_rdata;

  function automatic logic [AW-1:0] lalign(input logic [AW-1:0] a);
    return {a[AW-1:4], 4'h0};
  endfunction

  function automatic int tcount(input int e);
    int n = 0;
    foreach (tq[k]) if (tq[k].ent == e) n++;
    return n;
  endfunction

  task automatic mreset();
    foreach (st[i]) st[i] = 0;
    tq.delete();
    ihold = 0; rhold = 0; merr = 0; mocc = 0; iidx = 0; ridx = 0;
  endtask

  task automatic predict();
    e_hit = -1; e_free = -1; e_midx = -1; e_ridx = -1;
    for (int i = NE-1; i >= 0; i--) begin
      if (st[i] == 0) e_free = i;
      else if (mline[i] == lalign(alloc_addr)) e_hit = i;
      if (st[i] == 1) e_midx = i;
      if (st[i] == 3) e_ridx = i;
    end
    if (e_hit >= 0) e_ready = (st[e_hit] != 3) && (tcount(e_hit) < TGT);
    else            e_ready = (e_free >= 0);
    e_merged = alloc_valid && e_ready && (e_hit >= 0);
    if (ihold) e_midx = iidx;
    e_mv = (e_midx >= 0);
    e_maddr = e_mv ? mline[e_midx] : '0;
    e_mid = e_mv ? 4'(e_midx) : 4'h0;
    if (rhold) e_ridx = ridx;
    e_rv = (e_ridx >= 0);
    e_rid = '0; e_raddr = '0; e_rdata = '0;
    if (e_rv) begin
      for (int k = tq.size()-1; k >= 0; k--)
        if (tq[k].ent == e_ridx) begin e_rid = tq[k].id; e_raddr = tq[k].addr; end
      e_rdata = mdat[e_ridx];
    end
  endtask

  task automatic settle();
    int cand[$];
    if (auto_refill) begin
      refill_valid = 0;
      foreach (st[i]) if (st[i] == 2) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
        refill_valid = 1;
        refill_id = 4'(cand[$urandom_range(cand.size()-1, 0)]);
        refill_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    #1; predict();
  endtask

  task automatic advance();
    int occ_old = 0;
    @(posedge clk);
    foreach (st[i]) if (st[i] != 0) occ_old++;
    if (refill_valid) begin
      if (st[refill_id] == 2) begin st[refill_id] = 3; mdat[refill_id] = refill_data; end
      else merr = 1;
    end
    if (e_mv && mem_ready) st[e_midx] = 2;
    if (alloc_valid && e_ready) begin
      if (e_hit >= 0) tq.push_back('{e_hit, alloc_id, alloc_addr});
      else begin
        st[e_free] = 1; mline[e_free] = lalign(alloc_addr);
        tq.push_back('{e_free, alloc_id, alloc_addr});
      end
    end
    if (e_rv && resp_ready) begin
      for (int k = 0; k < tq.size(); k++)
        if (tq[k].ent == e_ridx) begin tq.delete(k); break; end
      if (tcount(e_ridx) == 0) st[e_ridx] = 0;
    end
    ihold = e_mv && !mem_ready; iidx = e_midx;
    rhold = e_rv && !resp_ready; ridx = e_ridx;
    mocc = occ_old;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; alloc_valid = 0; alloc_addr = '0; alloc_id = '0; mem_ready = 0;
    refill_valid = 0; refill_id = '0; refill_data = '0; resp_ready = 0; auto_refill = 0;
    mreset();
    #3;
    total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", alloc_ready_o); end
    total++; if (mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%0b exp=0", mem_req_valid_o); end
    total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid_o); end
    total++; if (occupancy_o !== 5'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
    total++; if (refill_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", refill_err_o); end
    total++; if (mem_req_addr_o !== '0 || resp_data_o !== '0) begin bad++; $display("FAIL rst_data got=%0h/%0h exp=0", mem_req_addr_o, resp_data_o); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alloc_issue();
    alloc_valid = 1; alloc_addr = 38'h100; alloc_id = 4'd3; settle();
    total++; if (alloc_ready_o !== e_ready) begin bad++; $display("FAIL ai_ready got=%0b exp=%0b", alloc_ready_o, e_ready); end
    total++; if (alloc_merged_o !== e_merged) begin bad++; $display("FAIL ai_merged got=%0b exp=%0b", alloc_merged_o, e_merged); end
    advance();
    alloc_valid = 0; mem_ready = 1; settle();
    total++; if (mem_req_valid_o !== e_mv) begin bad++; $display("FAIL ai_mem_valid got=%0b exp=%0b", mem_req_valid_o, e_mv); end
    total++; if (mem_req_addr_o !== e_maddr) begin bad++; $display("FAIL ai_mem_addr got=%0h exp=%0h", mem_req_addr_o, e_maddr); end
    total++; if (mem_req_id_o !== e_mid) begin bad++; $display("FAIL ai_mem_id got=%0d exp=%0d", mem_req_id_o, e_mid); end
    advance(); mem_ready = 0; settle(); advance(); settle();
    total++; if (occupancy_o !== 5'(mocc)) begin bad++; $display("FAIL ai_occ got=%0d exp=%0d", occupancy_o, mocc); end
  endtask

  task automatic test_merge_replay();
    logic [AW-1:0] ad[2] = '{38'h104, 38'h10C};
    logic [IW-1:0] id[2] = '{4'd5, 4'd6};
    for (int k = 0; k < 2; k++) begin
      alloc_valid = 1; alloc_addr = ad[k]; alloc_id = id[k]; settle();
      total++; if (alloc_ready_o !== e_ready) begin bad++; $display("FAIL mr_ready%0d got=%0b exp=%0b", k, alloc_ready_o, e_ready); end
      total++; if (alloc_merged_o !== e_merged) begin bad++; $display("FAIL mr_merged%0d got=%0b exp=%0b", k, alloc_merged_o, e_merged); end
      advance();
    end
    alloc_valid = 0; refill_valid = 1; refill_id = 4'd0; refill_data = {$urandom, $urandom, $urandom, $urandom};
    settle(); advance();
    refill_valid = 0; resp_ready = 1;
    for (int c = 0; c < 6; c++) begin
      settle();
      total++; if (resp_valid_o !== e_rv) begin bad++; $display("FAIL mr_resp_valid c%0d got=%0b exp=%0b", c, resp_valid_o, e_rv); end
      total++; if (resp_req_id_o !== e_rid || resp_addr_o !== e_raddr) begin bad++; $display("FAIL mr_resp_id_addr c%0d got=%0d/%0h exp=%0d/%0h", c, resp_req_id_o, resp_addr_o, e_rid, e_raddr); end
      total++; if (resp_data_o !== e_rdata) begin bad++; $display("FAIL mr_resp_data c%0d got=%0h exp=%0h", c, resp_data_o, e_rdata); end
      advance();
    end
    settle();
    total++; if (occupancy_o !== 5'(mocc)) begin bad++; $display("FAIL mr_occ got=%0d exp=%0d", occupancy_o, mocc); end
    advance();
  endtask

  task automatic flush();
    bit done = 0;
    alloc_valid = 0; mem_ready = 1; resp_ready = 1; auto_refill = 1;
    for (int c = 0; c < 600 && !done; c++) begin
      settle();
      total++; if (resp_valid_o !== e_rv || resp_req_id_o !== e_rid || resp_addr_o !== e_raddr || resp_data_o !== e_rdata) begin bad++; $display("FAIL fl_resp c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, resp_valid_o, resp_req_id_o, resp_addr_o, e_rv, e_rid, e_raddr); end
      done = 1;
      foreach (st[i]) if (st[i] != 0) done = 0;
      advance();
    end
    if (!done) begin total++; bad++; $display("FAIL fl_timeout got=busy exp=idle"); end
    auto_refill = 0; refill_valid = 0;
    settle(); advance(); settle();
    total++; if (occupancy_o !== 5'(mocc)) begin bad++; $display("FAIL fl_occ got=%0d exp=%0d", occupancy_o, mocc); end
    advance();
  endtask

  task automatic test_fill();
    bit got = 0;
    mem_ready = 0;
    for (int i = 0; i <= NE; i++) begin
      alloc_valid = 1; alloc_addr = 38'h4000 + 38'(i * 16); alloc_id = 4'(i); settle();
      total++; if (alloc_ready_o !== e_ready) begin bad++; $display("FAIL fill_ready%0d got=%0b exp=%0b", i, alloc_ready_o, e_ready); end
      advance();
    end
    mem_ready = 1;
    for (int c = 0; c < NE + 2; c++) begin
      settle();
      total++; if (mem_req_valid_o !== e_mv || mem_req_id_o !== e_mid || mem_req_addr_o !== e_maddr) begin bad++; $display("FAIL fill_issue c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, mem_req_valid_o, mem_req_id_o, mem_req_addr_o, e_mv, e_mid, e_maddr); end
      advance();
    end
    refill_valid = 1; refill_id = 4'd2; refill_data = {$urandom, $urandom, $urandom, $urandom};
    settle(); advance(); refill_valid = 0; resp_ready = 1;
    for (int c = 0; c < 20 && !got; c++) begin
      settle();
      total++; if (alloc_ready_o !== e_ready) begin bad++; $display("FAIL fill_reuse_ready c%0d got=%0b exp=%0b", c, alloc_ready_o, e_ready); end
      got = e_ready;
      advance();
    end
    if (!got) begin total++; bad++; $display("FAIL fill_reuse_timeout got=0 exp=1"); end
    alloc_valid = 0; mem_ready = 0; settle();
    total++; if (mem_req_valid_o !== e_mv || mem_req_id_o !== e_mid) begin bad++; $display("FAIL fill_reuse_id got=%0b/%0d exp=%0b/%0d", mem_req_valid_o, mem_req_id_o, e_mv, e_mid); end
    advance();
    flush();
  endtask

  task automatic test_targets();
    logic [AW-1:0] ad[5] = '{38'h200, 38'h204, 38'h208, 38'h20C, 38'h201};
    bit got = 0;
    mem_ready = 1; resp_ready = 1; auto_refill = 0; refill_valid = 0;
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1; alloc_addr = ad[k]; alloc_id = 4'(8 + k); settle();
      total++; if (alloc_ready_o !== e_ready || alloc_merged_o !== e_merged) begin bad++; $display("FAIL tg_alloc%0d got=%0b/%0b exp=%0b/%0b", k, alloc_ready_o, alloc_merged_o, e_ready, e_merged); end
      advance();
    end
    alloc_addr = ad[4]; alloc_id = 4'd12;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (alloc_ready_o !== e_ready) begin bad++; $display("FAIL tg_full c%0d got=%0b exp=%0b", c, alloc_ready_o, e_ready); end
      advance();
    end
    auto_refill = 1;
    for (int c = 0; c < 60 && !got; c++) begin
      settle();
      total++; if (alloc_ready_o !== e_ready || alloc_merged_o !== e_merged) begin bad++; $display("FAIL tg_fifth c%0d got=%0b/%0b exp=%0b/%0b", c, alloc_ready_o, alloc_merged_o, e_ready, e_merged); end
      got = e_ready;
      advance();
    end
    if (!got) begin total++; bad++; $display("FAIL tg_timeout got=0 exp=1"); end
    flush();
  endtask

  task automatic test_random();
    auto_refill = 1;
    for (int c = 0; c < 500; c++) begin
      alloc_valid = ($urandom_range(3, 0) != 0);
      alloc_addr = 38'h8000 + 38'($urandom_range(5, 0) * 16) + 38'($urandom_range(15, 0));
      alloc_id = 4'($urandom);
      mem_ready = $urandom_range(1, 0);
      resp_ready = ($urandom_range(3, 0) != 0);
      settle();
      total++; if (alloc_ready_o !== e_ready || alloc_merged_o !== e_merged) begin bad++; $display("FAIL rnd_alloc c%0d got=%0b/%0b exp=%0b/%0b", c, alloc_ready_o, alloc_merged_o, e_ready, e_merged); end
      total++; if (mem_req_valid_o !== e_mv || mem_req_id_o !== e_mid || mem_req_addr_o !== e_maddr) begin bad++; $display("FAIL rnd_mem c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, mem_req_valid_o, mem_req_id_o, mem_req_addr_o, e_mv, e_mid, e_maddr); end
      total++; if (resp_valid_o !== e_rv || resp_req_id_o !== e_rid || resp_addr_o !== e_raddr) begin bad++; $display("FAIL rnd_resp c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, resp_valid_o, resp_req_id_o, resp_addr_o, e_rv, e_rid, e_raddr); end
      total++; if (resp_data_o !== e_rdata) begin bad++; $display("FAIL rnd_data c%0d got=%0h exp=%0h", c, resp_data_o, e_rdata); end
      total++; if (occupancy_o !== 5'(mocc) || refill_err_o !== merr) begin bad++; $display("FAIL rnd_occ_err c%0d got=%0d/%0b exp=%0d/%0b", c, occupancy_o, refill_err_o, mocc, merr); end
      advance();
    end
    flush();
  endtask

  task automatic test_refill_err();
    refill_valid = 1; refill_id = 4'd7; refill_data = {$urandom, $urandom, $urandom, $urandom};
    settle(); advance(); refill_valid = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (refill_err_o !== merr) begin bad++; $display("FAIL re_err c%0d got=%0b exp=%0b", c, refill_err_o, merr); end
      total++; if (resp_valid_o !== e_rv) begin bad++; $display("FAIL re_resp c%0d got=%0b exp=%0b", c, resp_valid_o, e_rv); end
      advance();
    end
  endtask

  task automatic test_stall_reset();
    mem_ready = 1; resp_ready = 0;
    alloc_valid = 1; alloc_addr = 38'h300; alloc_id = 4'd9; settle(); advance();
    alloc_addr = 38'h308; alloc_id = 4'd10; settle(); advance();
    alloc_valid = 0; settle(); advance();
    refill_valid = 1; refill_id = 4'd0; refill_data = {$urandom, $urandom, $urandom, $urandom};
    settle(); advance(); refill_valid = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (resp_valid_o !== e_rv || resp_req_id_o !== e_rid || resp_addr_o !== e_raddr || resp_data_o !== e_rdata) begin bad++; $display("FAIL sr_stall c%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", c, resp_valid_o, resp_req_id_o, resp_addr_o, e_rv, e_rid, e_raddr); end
      advance();
    end
    resp_ready = 1; rst = 1; #1;
    total++; if (resp_valid_o !== 1'b0 || resp_req_id_o !== '0 || resp_addr_o !== '0 || resp_data_o !== '0) begin bad++; $display("FAIL sr_rst_resp got=%0b/%0d/%0h exp=0", resp_valid_o, resp_req_id_o, resp_addr_o); end
    total++; if (alloc_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0 || refill_err_o !== 1'b0) begin bad++; $display("FAIL sr_rst_ctl got=%0b/%0b/%0b exp=0", alloc_ready_o, mem_req_valid_o, refill_err_o); end
    total++; if (occupancy_o !== 5'd0) begin bad++; $display("FAIL sr_rst_occ got=%0d exp=0", occupancy_o); end
    mreset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    settle();
    total++; if (alloc_ready_o !== e_ready || occupancy_o !== 5'(mocc)) begin bad++; $display("FAIL sr_post got=%0b/%0d exp=%0b/%0d", alloc_ready_o, occupancy_o, e_ready, mocc); end
    advance();
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_alloc_issue();
    test_merge_replay();
    test_fill();
    test_targets();
    test_random();
    test_refill_err();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_mshr_file.md
Name: dcache_mshr_file

Overview:
Parametrised miss status holding register file for the data cache. It generalises the fixed 16-entry MSHR to configurable depth, line width and per-entry secondary-miss target count. It sits between the dcache miss path and the memory/refill interface. It tracks outstanding line misses, merges secondary misses to the same line, issues line fetches, and replays every waiting request once the refill returns.

Parameters:
MSHR_DEPTH, 16, number of entries (power of two, >=2)
ADDR_WIDTH, 38, physical byte address width
LINE_WIDTH, 128, cache line width in bits
REQ_ID_WIDTH, 4, core request id width
TARGETS, 4, max requests (primary + secondary) per entry

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
alloc_valid_i  in  1  miss request from dcache
alloc_ready_o  out  1  miss accepted this cycle
alloc_addr_i  in  ADDR_WIDTH  byte address of missing access
alloc_req_id_i  in  REQ_ID_WIDTH  core request id
alloc_merged_o  out  1  accepted request merged into an existing entry (valid with handshake)
mem_req_valid_o  out  1  line fetch request
mem_req_ready_i  in  1  memory accepts fetch
mem_req_addr_o  out  ADDR_WIDTH  line-aligned address (offset bits zero)
mem_req_id_o  out  $clog2(MSHR_DEPTH)  entry index used as transaction id
refill_valid_i  in  1  refill beat (full line, single beat)
refill_id_i  in  $clog2(MSHR_DEPTH)  entry index of refill
refill_data_i  in  LINE_WIDTH  line data
resp_valid_o  out  1  replay of one waiting request
resp_ready_i  in  1  consumer accepts replay
resp_req_id_o  out  REQ_ID_WIDTH  request id being replayed
resp_addr_o  out  ADDR_WIDTH  original byte address of the request
resp_data_o  out  LINE_WIDTH  refilled line
occupancy_o  out  $clog2(MSHR_DEPTH)+1  number of non-FREE entries
refill_err_o  out  1  sticky; refill to an entry not in ISSUED

Behaviour:
- Reset: all entries FREE; all valid/ready outputs 0; occupancy_o 0; refill_err_o 0; data outputs 0.
- Per-entry states: FREE -> PENDING (allocated) -> ISSUED (mem handshake) -> REPLAY (refill received) -> FREE (last target popped).
- Line match: compare alloc_addr_i[ADDR_WIDTH-1:offsetWidth] against the line address of every PENDING/ISSUED entry.
- alloc_ready_o is combinational from registered state plus alloc_addr_i:
  - match and target count < TARGETS -> ready; merge; alloc_merged_o=1.
  - match and targets full -> not ready.
  - match against a REPLAY entry -> not ready until that entry is FREE.
  - no match and a FREE entry exists -> ready; allocate lowest-index FREE entry; target 0 = request.
  - no match and no FREE entry -> not ready.
- An entry freed in cycle N is allocatable from cycle N+1.
- Issue: mem_req_valid_o for the lowest-index PENDING entry. It holds address and id stable until mem_req_ready_i. An entry allocated in cycle N may issue from cycle N+1.
- Merge into a PENDING or ISSUED entry is allowed, including in the same cycle as its mem handshake.
- Refill: refill_data_i is latched into the entry's line buffer and the state moves ISSUED -> REPLAY next cycle. There is no backpressure on refill. A refill to a non-ISSUED entry is dropped and sets refill_err_o.
- Replay: one entry replays at a time, chosen as the lowest-index REPLAY entry. Its targets are emitted in insertion order, one per resp handshake, with resp_* stable while valid && !ready. The first replay is one cycle after the refill. After the last target is accepted, the entry becomes FREE next cycle.
- Simultaneous alloc-merge and replay of the same entry cannot occur (rule above).
- occupancy_o is updated one cycle after the state change.

Optional Feature:
DCACHE_MSHR_MERGE_EN
- Defined: secondary-miss merging as above.
- Undefined: TARGETS is treated as 1. A line match always deasserts alloc_ready_o; alloc_merged_o is tied 0.

Test Plan:
- Reset, then alloc 0x100 id 3 -> ready=1, merged=0; next cycle mem_req valid with addr 0x100, id 0; occupancy_o=1.
- Alloc 0x104 id 5 and 0x10C id 6 while entry 0 is ISSUED -> both merged=1. Refill id 0 data D -> resp ids 3, 5, 6 in order with addrs 0x100, 0x104, 0x10C and data D. Entry FREE after; occupancy_o returns to 0.
- Fill all 16 entries with distinct lines -> 17th distinct alloc sees ready=0. Refill and drain entry 2 -> next alloc lands in entry 2, one cycle after it frees.
- Five allocs to line 0x200 with TARGETS=4 -> fifth held at ready=0 until that entry frees, then allocated as a new primary.
- Refill to FREE entry 7 -> refill_err_o=1 and stays 1; no resp_valid_o.
- resp_ready_i held 0 for 3 cycles during replay -> resp_* stable. Assert rst_i mid-replay -> all outputs 0 immediately; occupancy_o=0.
